// File: rtl/lud2x2_seq_if.sv
// Request/result handshake bundle for lud2x2_seq.
// Master drives requests and accepts results; slave is the sequencer.
interface lud2x2_seq_if #(
  parameter int DW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [4*DW-1:0] A;
  logic            out_valid;
  logic            out_ready;
  logic [4*DW-1:0] L;
  logic [4*DW-1:0] U;
  logic [2:0]      status;

  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, L, U, status
  );

  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, L, U, status
  );
endinterface

// File: rtl/lud2x2_seq.sv
// Sequential Doolittle LU factorisation of one packed 2x2 matrix (serial divider + one MAC step).
// Optional cycle counter port enabled by defining LUD_CYCLE_CNT_EN.
module lud2x2_seq #(
  parameter int DW        = 8,
  parameter int FRAC_BITS = 4
`ifdef LUD_CYCLE_CNT_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  lud2x2_seq_if.slave     bus,
  output logic            busy
`ifdef LUD_CYCLE_CNT_EN
  , output logic [CNT_W-1:0] cycles
`endif
);

  localparam int QW  = DW + FRAC_BITS;
  localparam int BCW = $clog2(QW + 1);
  localparam logic [DW-1:0] ONE = DW'(1 << FRAC_BITS);

  typedef enum logic [2:0] {IDLE, CHECK, DIV, MAC, DONE} state_t;

  state_t state, next_state;

  logic [4*DW-1:0] a_reg;
  logic [DW:0]     rem;
  logic [QW-1:0]   dq;
  logic [BCW-1:0]  bit_cnt;
  logic [4*DW-1:0] l_reg, u_reg;
  logic [2:0]      status_reg;

  logic [DW-1:0]   a00, a01, a10, a11;
  logic [DW:0]     rem_shift, rem_sub;
  logic            ge;
  logic            l_sat, u_unf;
  logic [DW-1:0]   l10, u11;
  logic [2*DW-1:0] prod, p;

  assign a00 = a_reg[4*DW-1 -: DW];
  assign a01 = a_reg[3*DW-1 -: DW];
  assign a10 = a_reg[2*DW-1 -: DW];
  assign a11 = a_reg[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid) next_state = CHECK;
      CHECK:   next_state = (a00 == '0) ? DONE : DIV;
      DIV:     if (bit_cnt == BCW'(QW - 1)) next_state = MAC;
      MAC:     next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
  end

  // Restoring step: the remainder stays below the divisor, so DW+1 bits hold the shifted value.
  always_comb begin
    rem_shift = {rem[DW-1:0], dq[QW-1]};
    ge        = (rem_shift >= {1'b0, a00});
    rem_sub   = rem_shift - {1'b0, a00};
  end

  always_comb begin
    l_sat = |dq[QW-1:DW];
    l10   = l_sat ? {DW{1'b1}} : dq[DW-1:0];
    prod  = {{DW{1'b0}}, l10} * {{DW{1'b0}}, a01};
    p     = prod >> FRAC_BITS;
    u_unf = (p > {{DW{1'b0}}, a11});
    u11   = u_unf ? '0 : (a11 - p[DW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      rem     <= '0;
      dq      <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) a_reg <= bus.A;
        CHECK: begin
          rem     <= '0;
          dq      <= {a10, {FRAC_BITS{1'b0}}};
          bit_cnt <= '0;
        end
        DIV: begin
          rem     <= ge ? rem_sub : rem_shift;
          dq      <= {dq[QW-2:0], ge};
          bit_cnt <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Results are only written on the edge entering DONE and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_reg      <= '0;
      u_reg      <= '0;
      status_reg <= '0;
    end else if (state == CHECK && a00 == '0) begin
      l_reg      <= '0;
      u_reg      <= '0;
      status_reg <= 3'b100;
    end else if (state == MAC) begin
      l_reg      <= {ONE, {DW{1'b0}}, l10, ONE};
      u_reg      <= {a00, a01, {DW{1'b0}}, u11};
      status_reg <= {1'b0, l_sat, u_unf};
    end
  end

  assign bus.L      = l_reg;
  assign bus.U      = u_reg;
  assign bus.status = status_reg;

`ifdef LUD_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycles <= '0;
    else if (state == IDLE && bus.in_valid)
      cycles <= '0;
    else if (state == CHECK || state == DIV || state == MAC)
      cycles <= cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_lud2x2_seq.sv
// Directed self-checking bench for lud2x2_seq with hand-computed L/U/status and latency.
module tb_lud2x2_seq;

  logic clk;
  logic rst_n;
  logic busy;
`ifdef LUD_CYCLE_CNT_EN
  logic [15:0] cycles;
`endif

  int vectors;
  int miscompares;

  lud2x2_seq_if #(.DW(8)) bus ();

  lud2x2_seq #(.DW(8), .FRAC_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef LUD_CYCLE_CNT_EN
    , .cycles(cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Accept A, keep junk on the request side while busy, and check latency, results and release.
  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] exp_l, input logic [31:0] exp_u,
                               input logic [2:0] exp_st, input int exp_lat, input int hold);
    int n;
    logic [31:0] l_seen;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.A        = a;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.A = 32'hFFFF_FFFF;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    checkOutput({tag, ".latency"}, n, exp_lat);
    checkOutput({tag, ".L"}, bus.L, exp_l);
    checkOutput({tag, ".U"}, bus.U, exp_u);
    checkOutput({tag, ".status"}, {29'd0, bus.status}, {29'd0, exp_st});
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd1);
`ifdef LUD_CYCLE_CNT_EN
    checkOutput({tag, ".cycles"}, {16'd0, cycles}, exp_lat);
`endif
    l_seen = bus.L;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      checkOutput({tag, ".hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      checkOutput({tag, ".hold_L"}, bus.L, l_seen);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, ".released_valid"}, {31'd0, bus.out_valid}, 32'd0);
    checkOutput({tag, ".released_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    vectors      = 0;
    miscompares  = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    rst_n         = 1'b0;
    #23;
    checkOutput("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.L", bus.L, 32'd0);
    checkOutput("reset.U", bus.U, 32'd0);
    checkOutput("reset.status", {29'd0, bus.status}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("job1", 32'h04_06_02_09, 32'h10_00_08_10, 32'h04_06_00_06, 3'b000, 14, 5);
    applyStimulus("job2", 32'h03_09_01_07, 32'h10_00_05_10, 32'h03_09_00_05, 3'b000, 14, 0);
    applyStimulus("sing", 32'h00_05_03_02, 32'h00_00_00_00, 32'h00_00_00_00, 3'b100, 1, 0);
    applyStimulus("lsat", 32'h01_0A_14_64, 32'h10_00_FF_10, 32'h01_0A_00_00, 3'b011, 14, 0);
    applyStimulus("unf",  32'h01_0A_0F_64, 32'h10_00_F0_10, 32'h01_0A_00_00, 3'b001, 14, 0);
    applyStimulus("job6", 32'h02_03_05_14, 32'h10_00_28_10, 32'h02_03_00_0D, 3'b000, 14, 0);

    // Abort a job mid-division; nothing from it may surface afterwards.
    bus.A        = 32'h04_06_02_09;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort.busy", {31'd0, busy}, 32'd0);
    checkOutput("abort.in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("abort.out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("abort.L", bus.L, 32'd0);
    #4 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checkOutput("abort.quiet", seen, 32'd0);
    applyStimulus("post", 32'h03_09_01_07, 32'h10_00_05_10, 32'h03_09_00_05, 3'b000, 14, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
